dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_pkg.sv | 43 ++++
 rtl/dcache_sat_counter.sv | 32 +++
 rtl/dcache_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared defaults, derived widths, FSM state codes and the
//                cache line layout for the direct-mapped data cache control.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    // Default geometry; the controller re-derives its widths from its own
    // parameters so non-default instances stay consistent.
    localparam int c_INDEX_COUNT_DEF = 256;
    localparam int c_TAG_W_DEF       = 20;
    localparam int c_DATA_W_DEF      = 11;
    localparam int c_IDX_W_DEF       = $clog2(c_INDEX_COUNT_DEF);
    localparam int c_ADDR_W_DEF      = c_TAG_W_DEF + c_IDX_W_DEF;
    localparam int c_LINE_W_DEF      = 1 + c_TAG_W_DEF + c_DATA_W_DEF;

    // Statistic counter width
    localparam int c_CNT_W = 16;

    // Controller state encoding
    localparam int c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_INIT     = 3'd0;
    localparam state_t c_ST_IDLE     = 3'd1;
    localparam state_t c_ST_LOOKUP   = 3'd2;
    localparam state_t c_ST_MEM_REQ  = 3'd3;
    localparam state_t c_ST_MEM_WAIT = 3'd4;
    localparam state_t c_ST_FILL     = 3'd5;
    localparam state_t c_ST_RESP     = 3'd6;
    localparam state_t c_ST_FLUSH    = 3'd7;

    // Line layout at default geometry: {valid, tag, data}
    typedef struct packed {
        logic                    valid;
        logic [c_TAG_W_DEF-1:0]  tag;
        logic [c_DATA_W_DEF-1:0] data;
    } line_t;

endpackage : dcache_pkg
`default_nettype wire

// File: rtl/dcache_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_sat_counter
//  Description : Up-counter that sticks at its all-ones value.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_sat_counter
    import dcache_pkg::*;
#(
    parameter int WIDTH = c_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Count increment requests, holding once the maximum is reached
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : dcache_sat_counter
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl
//  Description : Direct-mapped, write-through / write-allocate data cache
//                controller with an external line array, a simple backing
//                memory handshake, an invalidate-all sweep and hit/miss
//                statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter  int INDEX_COUNT = c_INDEX_COUNT_DEF,
    parameter  int TAG_W       = c_TAG_W_DEF,
    parameter  int DATA_W      = c_DATA_W_DEF,
    localparam int IDX_W       = $clog2(INDEX_COUNT),
    localparam int ADDR_W      = TAG_W + IDX_W,
    localparam int LINE_W      = 1 + TAG_W + DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    // CPU request / response
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    // Invalidate-all
    input  logic              flush,
    output logic              flush_busy,
    // Line array
    output logic              arr_en,
    output logic              arr_we,
    output logic [IDX_W-1:0]  arr_index,
    output logic [LINE_W-1:0] arr_wline,
    input  logic [LINE_W-1:0] arr_rline,
    // Backing memory
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    // Statistics
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(INDEX_COUNT - 1);

    state_t             r_state;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_hit;
    logic               r_flush_pend;
    logic               r_init_armed;
    logic [IDX_W-1:0]   r_sweep_idx;

    logic [IDX_W-1:0]   w_req_idx;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_line_valid;
    logic [TAG_W-1:0]   w_line_tag;
    logic [DATA_W-1:0]  w_line_data;
    logic               w_hit;
    logic               w_sweep;
    logic               w_sweep_last;
    logic               w_flush_take;
    logic               w_cnt_hit;
    logic               w_cnt_miss;

    assign w_req_idx    = req_addr[IDX_W-1:0];
    assign w_idx        = r_addr[IDX_W-1:0];
    assign w_tag        = r_addr[ADDR_W-1:IDX_W];
    assign w_line_valid = arr_rline[LINE_W-1];
    assign w_line_tag   = arr_rline[LINE_W-2 -: TAG_W];
    assign w_line_data  = arr_rline[DATA_W-1:0];
    assign w_hit        = w_line_valid && (w_line_tag == w_tag);

    // INIT spends one quiet cycle after reset before sweeping, so every
    // output reads zero in the cycle right after rst was sampled high.
    assign w_sweep      = (r_state == c_ST_FLUSH) ||
                          ((r_state == c_ST_INIT) && r_init_armed);
    assign w_sweep_last = (r_sweep_idx == c_LAST_IDX);
    // A same-cycle flush pulse blocks acceptance so it wins over req_valid
    assign w_flush_take = flush || r_flush_pend;

    assign req_ready  = (r_state == c_ST_IDLE) && !w_flush_take;
    assign flush_busy = w_sweep;

    assign resp_valid = (r_state == c_ST_RESP);
    assign resp_rdata = resp_valid ? r_rdata : '0;
    assign resp_hit   = resp_valid && r_hit;

    assign mem_req_valid = (r_state == c_ST_MEM_REQ);
    assign mem_we        = mem_req_valid && r_we;
    assign mem_addr      = mem_req_valid ? r_addr : '0;
    assign mem_wdata     = mem_we ? r_wdata : '0;

    // Array port: lookup read on acceptance, write-allocate, fill, sweep
    always_comb begin
        arr_en    = 1'b0;
        arr_we    = 1'b0;
        arr_index = '0;
        arr_wline = '0;
        case (r_state)
            c_ST_IDLE: begin
                arr_en    = req_valid && req_ready;
                arr_index = w_req_idx;
            end
            c_ST_LOOKUP: begin
                if (r_we) begin
                    arr_en    = 1'b1;
                    arr_we    = 1'b1;
                    arr_index = w_idx;
                    arr_wline = {1'b1, w_tag, r_wdata};
                end
            end
            c_ST_FILL: begin
                arr_en    = 1'b1;
                arr_we    = 1'b1;
                arr_index = w_idx;
                arr_wline = {1'b1, w_tag, r_rdata};
            end
            c_ST_INIT, c_ST_FLUSH: begin
                if (w_sweep) begin
                    arr_en    = 1'b1;
                    arr_we    = 1'b1;
                    arr_index = r_sweep_idx;
                end
            end
            default: begin
            end
        endcase
    end

    // Controller state, request capture and flush latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_INIT;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_hit        <= 1'b0;
            r_flush_pend <= 1'b0;
            r_init_armed <= 1'b0;
            r_sweep_idx  <= '0;
        end else begin
            if (flush) begin
                r_flush_pend <= 1'b1;
            end
            case (r_state)
                c_ST_INIT: begin
                    if (!r_init_armed) begin
                        r_init_armed <= 1'b1;
                    end else begin
                        r_sweep_idx <= r_sweep_idx + 1'b1;
                        if (w_sweep_last) begin
                            r_sweep_idx  <= '0;
                            r_init_armed <= 1'b0;
                            r_state      <= c_ST_IDLE;
                        end
                    end
                end
                c_ST_IDLE: begin
                    if (w_flush_take) begin
                        r_flush_pend <= 1'b0;
                        r_sweep_idx  <= '0;
                        r_state      <= c_ST_FLUSH;
                    end else if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_state <= c_ST_LOOKUP;
                    end
                end
                c_ST_LOOKUP: begin
                    r_hit <= w_hit;
                    if (r_we) begin
                        r_rdata <= '0;
                        r_state <= c_ST_MEM_REQ;
                    end else if (w_hit) begin
                        r_rdata <= w_line_data;
                        r_state <= c_ST_RESP;
                    end else begin
                        r_state <= c_ST_MEM_REQ;
                    end
                end
                c_ST_MEM_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= c_ST_MEM_WAIT;
                    end
                end
                c_ST_MEM_WAIT: begin
                    if (mem_rvalid) begin
                        if (r_we) begin
                            r_state <= c_ST_RESP;
                        end else begin
                            r_rdata <= mem_rdata;
                            r_state <= c_ST_FILL;
                        end
                    end
                end
                c_ST_FILL: begin
                    r_state <= c_ST_RESP;
                end
                c_ST_RESP: begin
                    if (resp_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_FLUSH: begin
                    r_sweep_idx <= r_sweep_idx + 1'b1;
                    if (w_sweep_last) begin
                        r_sweep_idx <= '0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_INIT;
                end
            endcase
        end
    end

    // Only reads are counted, once each, at the lookup decision
    assign w_cnt_hit  = (r_state == c_ST_LOOKUP) && !r_we && w_hit;
    assign w_cnt_miss = (r_state == c_ST_LOOKUP) && !r_we && !w_hit;

    dcache_sat_counter #(
        .WIDTH (16)
    ) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_cnt_hit),
        .count (hit_count)
    );

    dcache_sat_counter #(
        .WIDTH (16)
    ) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_cnt_miss),
        .count (miss_count)
    );

endmodule : dcache_ctrl
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_ctrl
//  Description : Directed self-checking bench for dcache_ctrl with a
//                behavioural line array and a handshake-driven memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;
    import dcache_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [27:0] req_addr;
    logic [10:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [10:0] resp_rdata;
    logic        resp_hit;
    logic        flush;
    logic        flush_busy;
    logic        arr_en;
    logic        arr_we;
    logic [7:0]  arr_index;
    logic [31:0] arr_wline;
    logic [31:0] arr_rline;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [27:0] mem_addr;
    logic [10:0] mem_wdata;
    logic        mem_rvalid;
    logic [10:0] mem_rdata;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    logic        preload;
    logic [31:0] arr_model [0:255];

    int n_checks = 0;
    int n_errors = 0;

    dcache_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_hit      (resp_hit),
        .flush         (flush),
        .flush_busy    (flush_busy),
        .arr_en        (arr_en),
        .arr_we        (arr_we),
        .arr_index     (arr_index),
        .arr_wline     (arr_wline),
        .arr_rline     (arr_rline),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line array: synchronous write, registered read; preload fills every
    // line with a valid tag-1 entry so an incomplete sweep shows up as a hit.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) begin
                arr_model[i] <= {1'b1, 20'h00001, 11'(i)};
            end
        end else if (arr_en) begin
            if (arr_we) arr_model[arr_index] <= arr_wline;
            else        arr_rline <= arr_model[arr_index];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic line_t mk_line(input logic [19:0] tag, input logic [10:0] data);
        line_t l;
        l.valid = 1'b1;
        l.tag   = tag;
        l.data  = data;
        return l;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Measure one invalidate sweep starting at or shortly after this negedge
    task automatic sweep_check(input string tag);
        int n;
        int bad;
        int w;
        n = 0; bad = 0; w = 0;
        while (!flush_busy && w < 10) begin
            @(negedge clk);
            w++;
        end
        while (flush_busy && n < 400) begin
            if (!(arr_en && arr_we && (arr_wline == 32'h0) && (arr_index == 8'(n)))) bad++;
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, n, 256);
        check({tag, "_sweep_writes_bad"}, bad, 0);
        check({tag, "_ready_after"}, req_ready, 1'b1);
    endtask

    // One full CPU transaction with a cooperative memory; memory ready is
    // withheld for one cycle so request stability can be observed.
    task automatic do_req(input string tag, input logic we, input logic [27:0] addr,
                          input logic [10:0] wdata, input logic [10:0] mdata,
                          input logic exp_mem, input logic [10:0] exp_rdata,
                          input logic exp_hit, input logic exp_wr, input logic [31:0] exp_line);
        int          w;
        int          resp_c;
        int          ready_c;
        logic        done;
        logic        mem_seen;
        logic        mem_stable;
        logic        wr_seen;
        logic [27:0] m_addr;
        logic        m_we;
        logic [10:0] m_wdata;
        logic [31:0] wr_line;
        logic [7:0]  wr_idx;
        logic [7:0]  exp_idx;
        done = 0; mem_seen = 0; mem_stable = 1; wr_seen = 0;
        m_addr = '0; m_we = 0; m_wdata = '0; wr_line = '0; wr_idx = '0;
        resp_c = 0; ready_c = 0;
        exp_idx = addr[7:0];

        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        #1;
        w = 0;
        while (!req_ready && w < 400) begin
            @(negedge clk); #1;
            w++;
        end
        check({tag, "_accept"}, req_ready, 1'b1);
        check({tag, "_arr_read_issue"}, {arr_en, arr_we, arr_index}, {1'b1, 1'b0, exp_idx});

        for (int c = 1; c <= 60 && !done; c++) begin
            @(negedge clk);
            req_valid = 1'b0; mem_req_ready = 1'b0; mem_rvalid = 1'b0;
            if (resp_valid) begin
                done   = 1;
                resp_c = c;
            end else begin
                if (arr_en && arr_we) begin
                    wr_seen = 1; wr_line = arr_wline; wr_idx = arr_index;
                end
                if (mem_req_valid) begin
                    if (!mem_seen) begin
                        mem_seen = 1; m_addr = mem_addr; m_we = mem_we; m_wdata = mem_wdata;
                    end else begin
                        if (mem_addr !== m_addr || mem_we !== m_we || mem_wdata !== m_wdata) mem_stable = 0;
                        mem_req_ready = 1'b1;
                        ready_c = c;
                    end
                end
                if (ready_c > 0 && c == ready_c + 2) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mdata;
                end
            end
        end

        check({tag, "_resp_seen"}, done, 1'b1);
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_hit"}, resp_hit, exp_hit);
        check({tag, "_mem_issued"}, mem_seen, exp_mem);
        if (exp_mem) begin
            check({tag, "_mem_addr"}, m_addr, addr);
            check({tag, "_mem_we"}, m_we, we);
            check({tag, "_mem_wdata"}, m_wdata, we ? wdata : 11'h0);
            check({tag, "_mem_stable"}, mem_stable, 1'b1);
        end else begin
            check({tag, "_resp_latency"}, resp_c, 2);
        end
        check({tag, "_arr_write"}, wr_seen, exp_wr);
        if (exp_wr) begin
            check({tag, "_arr_wline"}, wr_line, exp_line);
            check({tag, "_arr_widx"}, wr_idx, exp_idx);
        end

        // Response must hold until consumed
        resp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_resp_hold"}, {resp_valid, resp_rdata}, {1'b1, exp_rdata});
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, "_resp_release"}, {resp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        int w;
        rst = 1'b1; preload = 1'b1;
        req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; resp_ready = 0;
        flush = 0; mem_req_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        @(negedge clk);
        preload = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_outputs", {flush_busy, req_ready, mem_req_valid, resp_valid, arr_en, arr_we}, 0);
        check("rst_counts", {hit_count, miss_count}, 0);

        // Power-up sweep
        rst = 1'b0;
        sweep_check("init");
        check("init_arr_cleared", arr_model[5] | arr_model[255] | arr_model[0], 0);

        // Cold read miss with fill
        do_req("rd_miss", 1'b0, 28'h0000105, 11'h0, 11'h2A5, 1'b1, 11'h2A5, 1'b0,
               1'b1, mk_line(20'h00001, 11'h2A5));
        check("rd_miss_counts", {hit_count, miss_count}, {16'd0, 16'd1});
        check("rd_miss_arr5", arr_model[5], mk_line(20'h00001, 11'h2A5));

        // Same address hits
        do_req("rd_hit", 1'b0, 28'h0000105, 11'h0, 11'h0, 1'b0, 11'h2A5, 1'b1, 1'b0, 32'h0);
        check("rd_hit_counts", {hit_count, miss_count}, {16'd1, 16'd1});

        // Conflicting write allocates and writes through
        do_req("wr_conflict", 1'b1, 28'h0000205, 11'h111, 11'h7FF, 1'b1, 11'h000, 1'b0,
               1'b1, mk_line(20'h00002, 11'h111));
        check("wr_conflict_arr5", arr_model[5], mk_line(20'h00002, 11'h111));
        check("wr_conflict_counts", {hit_count, miss_count}, {16'd1, 16'd1});

        // Original tag is now evicted
        do_req("rd_evicted", 1'b0, 28'h0000105, 11'h0, 11'h155, 1'b1, 11'h155, 1'b0,
               1'b1, mk_line(20'h00001, 11'h155));
        check("rd_evicted_counts", {hit_count, miss_count}, {16'd1, 16'd2});

        // Write hit then read back the new data
        do_req("wr_hit", 1'b1, 28'h0000105, 11'h0AB, 11'h000, 1'b1, 11'h000, 1'b1,
               1'b1, mk_line(20'h00001, 11'h0AB));
        do_req("rd_after_wr", 1'b0, 28'h0000105, 11'h0, 11'h0, 1'b0, 11'h0AB, 1'b1, 1'b0, 32'h0);
        check("wr_rd_counts", {hit_count, miss_count}, {16'd2, 16'd2});

        // Flush and request in the same idle cycle: sweep goes first
        flush = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 28'h0000105; req_wdata = '0;
        #1;
        check("flush_prio_ready", {req_ready, arr_en}, 2'b00);
        @(negedge clk);
        flush = 1'b0;
        sweep_check("flush");
        do_req("rd_after_flush", 1'b0, 28'h0000105, 11'h0, 11'h0C3, 1'b1, 11'h0C3, 1'b0,
               1'b1, mk_line(20'h00001, 11'h0C3));
        check("flush_counts", {hit_count, miss_count}, {16'd2, 16'd3});

        // Reset while waiting on memory
        req_valid = 1'b1; req_we = 1'b0; req_addr = 28'h0000305;
        #1;
        check("rstmw_accept", req_ready, 1'b1);
        w = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            w++;
        end while (!mem_req_valid && w < 20);
        check("rstmw_memreq", mem_req_valid, 1'b1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rstmw_mem_clr", mem_req_valid, 1'b0);
        check("rstmw_resp_clr", resp_valid, 1'b0);
        check("rstmw_counts_clr", {hit_count, miss_count}, 0);
        check("rstmw_busy_clr", flush_busy, 1'b0);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 11'h5A5;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("rstmw_late_rvalid", {resp_valid, mem_req_valid}, 2'b00);
        sweep_check("reinit");
        check("reinit_counts", {hit_count, miss_count}, 0);
        do_req("rd_after_rst", 1'b0, 28'h0000305, 11'h0, 11'h1A1, 1'b1, 11'h1A1, 1'b0,
               1'b1, mk_line(20'h00003, 11'h1A1));
        check("rd_after_rst_counts", {hit_count, miss_count}, {16'd0, 16'd1});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dcache_ctrl
`default_nettype wire
